ucsbece154b_dual_issue_scheduler: RTL and testbench
===================================================

# ucsbece154b_dual_issue_scheduler

Instruction buffer and dual-issue scheduler between the two-wide fetch stage and the two decode slots of the superscalar pipeline. It stores fetched instructions in a circular queue and presents the oldest one or two entries to decode each cycle. It issues the second entry only when the pair is free of intra-pair hazards and resource conflicts. It also keeps performance counters used by the CPI and issue-rate benches.

## Interface
- DEPTH, 8, queue entries (power of two, ≥4)
- CNT_W, 32, performance counter width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- fetch_cnt_i  in  2  number of valid fetched instructions this cycle (0..2; 3 is ignored and treated as 0); slot 0 is older
- fetch_instr0_i, fetch_instr1_i  in  32  fetched instructions
- fetch_pc0_i, fetch_pc1_i  in  32  their PCs
- fetch_ready_o  out  1  queue can accept a fetch group (free entries ≥2)
- flush_i  in  1  mispredict or redirect; empties the queue
- stall_i  in  1  decode stall; nothing is dequeued
- issue0_valid_o, issue1_valid_o  out  1  slot valid
- issue0_instr_o, issue1_instr_o  out  32  slot instruction
- issue0_pc_o, issue1_pc_o  out  32  slot PC
- count_o  out  $clog2(DEPTH)+1  occupancy
- perf_issued_o  out  CNT_W  instructions dequeued
- perf_dual_o  out  CNT_W  cycles with two instructions dequeued
- perf_split_o  out  CNT_W  cycles with ≥2 entries but only slot 0 dequeued

## Operation
- Storage is a circular buffer with head and tail pointers that wrap modulo DEPTH. Entries store {instr, pc}.
- Enqueue occurs when fetch_ready_o=1, fetch_cnt_i∈{1,2} and flush_i=0. Instr0 is written at tail and instr1 at tail+1. Tail advances by fetch_cnt_i.
- If fetch_ready_o=0, any fetch group presented in that cycle is dropped. Fetch must hold its group.
- Slot 0 presents the entry at head. issue0_valid_o = (count≥1) & ~flush_i.
- Slot 1 presents the entry at head+1. issue1_valid_o = (count≥2) & ~flush_i & pair_ok.
- For the pair check, E0 is the head entry and E1 is head+1. pair_ok=0 if any of the following hold:
  - RAW: E0 writes a register and rd(E0)≠0, and rd(E0) equals rs1(E1) where E1 reads rs1, or equals rs2(E1) where E1 reads rs2.
  - WAW: both entries write a register and rd(E0)=rd(E1)≠0.
  - E0 is a control instruction (opcode 1100011, 1101111 or 1100111).
  - Both entries are memory ops (opcode 0000011 or 0100011); there is a single memory port.
- Register writers are opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111 and 1100111.
- rs1 readers are all opcodes except 0110111, 0010111 and 1101111.
- rs2 readers are opcodes 0110011, 0100011 and 1100011.
- Dequeue count is deq = stall_i ? 0 : (issue0_valid_o + issue1_valid_o). Head advances by deq.
- Occupancy update is count_next = count + enq − deq. Simultaneous enqueue and dequeue is legal, including when the queue is full at cycle start.
- Flush has priority over enqueue, dequeue and stall. Head, tail and count go to 0. The same-cycle fetch group is discarded. Performance counters are unaffected.
- Performance counters wrap modulo 2^CNT_W and update only on dequeue cycles:
  - perf_issued_o increments by deq.
  - perf_dual_o increments when deq=2.
  - perf_split_o increments when deq=1 and count≥2.

## Timing
- Reset values: head=tail=count=0, all valid outputs 0, fetch_ready_o=1, perf_* = 0. Instr/pc outputs are don't-care while their valid is 0.
- An entry enqueued in cycle N is first visible on the issue outputs in cycle N+1. There is no fetch-to-issue bypass.
- fetch_ready_o is a function of the registered count only: DEPTH−count ≥ 2.
- Issue outputs are combinational from registered state and flush_i. They do not depend on stall_i, so no loop forms through decode.
- Reset asserted mid-operation overrides flush and fetch and takes effect at the next clk edge.
- When a hazard blocks slot 1, the blocked entry becomes slot 0 in the next non-stalled cycle.

## Test plan
- **Reset.** Hold reset=0 for 2 cycles, then release. Required: count_o=0, both valids 0, fetch_ready_o=1, all perf counters 0.
- **Independent pair.** Push 0x00100293 and 0x00200313 at PC 0x0 and 0x4, with stall_i=0. Required next cycle: both valids 1 with pc 0x0 and 0x4. The cycle after: count_o=0, perf_issued_o=2, perf_dual_o=1.
- **RAW split.** Push 0x00100293 (addi x5) and 0x00128313 (addi x6,x5,1). Required: first cycle issues slot 0 only and perf_split_o=1. Next cycle 0x00128313 appears on slot 0 with pc 0x4.
- **Control in slot 0.** Push 0x00000463 (beq) and 0x00100293. Required: only the beq issues, then the addi issues alone in the next cycle.
- **Full and wrap.** Hold stall_i=1 and push four pairs with DEPTH=8. Required: count_o=8, fetch_ready_o=0, and a fifth push is ignored. Then release stall_i and keep pushing. Required: program order is preserved across the pointer wrap, draining two entries per cycle for independent pairs.
- **Flush.** With count_o=5 and a valid fetch group present, assert flush_i for 1 cycle. Required: valids are 0 in that cycle, count_o=0 the next cycle, the fetch group is dropped, and perf counters are unchanged.

Source files
------------

// File: rtl/ucsbece154b_dual_issue_scheduler_if.sv
// Fetch/decode bundle for the dual-issue scheduler: fetch group in, two issue slots out, plus
// occupancy and performance counters. The slave modport is the scheduler's view.
interface ucsbece154b_dual_issue_scheduler_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
);
  logic [1:0]               fetch_cnt_i;
  logic [31:0]              fetch_instr0_i;
  logic [31:0]              fetch_instr1_i;
  logic [31:0]              fetch_pc0_i;
  logic [31:0]              fetch_pc1_i;
  logic                     fetch_ready_o;
  logic                     flush_i;
  logic                     stall_i;
  logic                     issue0_valid_o;
  logic                     issue1_valid_o;
  logic [31:0]              issue0_instr_o;
  logic [31:0]              issue1_instr_o;
  logic [31:0]              issue0_pc_o;
  logic [31:0]              issue1_pc_o;
  logic [$clog2(DEPTH):0]   count_o;
  logic [CNT_W-1:0]         perf_issued_o;
  logic [CNT_W-1:0]         perf_dual_o;
  logic [CNT_W-1:0]         perf_split_o;

  modport slave (
    input  fetch_cnt_i, fetch_instr0_i, fetch_instr1_i, fetch_pc0_i, fetch_pc1_i,
    input  flush_i, stall_i,
    output fetch_ready_o,
    output issue0_valid_o, issue1_valid_o, issue0_instr_o, issue1_instr_o,
    output issue0_pc_o, issue1_pc_o,
    output count_o, perf_issued_o, perf_dual_o, perf_split_o
  );

  modport master (
    output fetch_cnt_i, fetch_instr0_i, fetch_instr1_i, fetch_pc0_i, fetch_pc1_i,
    output flush_i, stall_i,
    input  fetch_ready_o,
    input  issue0_valid_o, issue1_valid_o, issue0_instr_o, issue1_instr_o,
    input  issue0_pc_o, issue1_pc_o,
    input  count_o, perf_issued_o, perf_dual_o, perf_split_o
  );
endinterface

// File: rtl/ucsbece154b_dual_issue_scheduler.sv
// Circular instruction buffer feeding two decode slots; slot 1 only issues when the oldest pair
// is hazard-free. Issue outputs are combinational from registered state and flush, never stall.
module ucsbece154b_dual_issue_scheduler #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  ucsbece154b_dual_issue_scheduler_if.slave bus
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0]         r_instr [DEPTH];
  logic [31:0]         r_pc    [DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_BITS-1:0] r_count;
  logic [CNT_W-1:0]    r_perf_issued;
  logic [CNT_W-1:0]    r_perf_dual;
  logic [CNT_W-1:0]    r_perf_split;

  logic [PTR_W-1:0]    w_head1;
  logic [PTR_W-1:0]    w_tail1;
  logic [31:0]         w_e0;
  logic [31:0]         w_e1;
  logic                w_fetch_ready;
  logic                w_pair_ok;
  logic                w_v0;
  logic                w_v1;
  logic [1:0]          w_enq;
  logic [1:0]          w_deq;
  logic                w_multi;
  logic [CNT_BITS-1:0] w_count_next;

  function automatic logic is_writer(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_LUI) ||
           (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic logic reads_rs1(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic reads_rs2(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic is_ctrl(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic logic is_mem(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  assign w_head1 = r_head + PTR_W'(1);
  assign w_tail1 = r_tail + PTR_W'(1);
  assign w_e0    = r_instr[r_head];
  assign w_e1    = r_instr[w_head1];

  // Only registered count feeds ready, so fetch never sees a combinational path from decode.
  assign w_fetch_ready = (CNT_BITS'(DEPTH) - r_count) >= CNT_BITS'(2);
  assign w_multi       = r_count >= CNT_BITS'(2);

  always_comb begin
    logic raw;
    logic waw;
    raw = 1'b0;
    waw = 1'b0;
    if (is_writer(w_e0) && (w_e0[11:7] != 5'd0)) begin
      raw = (reads_rs1(w_e1) && (w_e0[11:7] == w_e1[19:15])) ||
            (reads_rs2(w_e1) && (w_e0[11:7] == w_e1[24:20]));
      waw = is_writer(w_e1) && (w_e0[11:7] == w_e1[11:7]);
    end
    w_pair_ok = !raw && !waw && !is_ctrl(w_e0) && !(is_mem(w_e0) && is_mem(w_e1));
  end

  assign w_v0 = (r_count != '0) && !bus.flush_i;
  assign w_v1 = w_multi && !bus.flush_i && w_pair_ok;

  always_comb begin
    w_enq = 2'd0;
    if (w_fetch_ready && !bus.flush_i &&
        ((bus.fetch_cnt_i == 2'd1) || (bus.fetch_cnt_i == 2'd2)))
      w_enq = bus.fetch_cnt_i;
    w_deq = 2'd0;
    if (!bus.stall_i)
      w_deq = {1'b0, w_v0} + {1'b0, w_v1};
    w_count_next = r_count + CNT_BITS'(w_enq) - CNT_BITS'(w_deq);
  end

  // Payload storage carries no reset; entries are only observed behind a valid count.
  always_ff @(posedge clk) begin
    if (w_enq != 2'd0) begin
      r_instr[r_tail] <= bus.fetch_instr0_i;
      r_pc[r_tail]    <= bus.fetch_pc0_i;
    end
    if (w_enq == 2'd2) begin
      r_instr[w_tail1] <= bus.fetch_instr1_i;
      r_pc[w_tail1]    <= bus.fetch_pc1_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + PTR_W'(w_enq);
      r_count <= w_count_next;
    end
  end

  // Flush forces both valids low, so deq is already zero and counters hold on their own.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_issued <= '0;
      r_perf_dual   <= '0;
      r_perf_split  <= '0;
    end else if (w_deq != 2'd0) begin
      r_perf_issued <= r_perf_issued + CNT_W'(w_deq);
      if (w_deq == 2'd2)
        r_perf_dual <= r_perf_dual + CNT_W'(1);
      if ((w_deq == 2'd1) && w_multi)
        r_perf_split <= r_perf_split + CNT_W'(1);
    end
  end

  assign bus.fetch_ready_o  = w_fetch_ready;
  assign bus.issue0_valid_o = w_v0;
  assign bus.issue1_valid_o = w_v1;
  assign bus.issue0_instr_o = w_e0;
  assign bus.issue1_instr_o = w_e1;
  assign bus.issue0_pc_o    = r_pc[r_head];
  assign bus.issue1_pc_o    = r_pc[w_head1];
  assign bus.count_o        = r_count;
  assign bus.perf_issued_o  = r_perf_issued;
  assign bus.perf_dual_o    = r_perf_dual;
  assign bus.perf_split_o   = r_perf_split;

endmodule

// File: tb/tb_ucsbece154b_dual_issue_scheduler.sv
// Directed vector table for the dual-issue scheduler plus a hand-written mid-operation reset.
// Each row drives one cycle's inputs and lists the outputs expected before that cycle's edge.
module tb_ucsbece154b_dual_issue_scheduler;

  localparam logic [31:0] ADDI5 = 32'h00100293;
  localparam logic [31:0] ADDI6 = 32'h00200313;
  localparam logic [31:0] DEP6  = 32'h00128313;
  localparam logic [31:0] BEQ   = 32'h00000463;
  localparam logic [31:0] LW5   = 32'h00002283;
  localparam logic [31:0] LW6   = 32'h00002303;

  typedef struct {
    logic [1:0]  cnt;
    logic [31:0] i0, i1, p0, p1;
    logic        flush, stall;
    logic        ev0, ev1;
    logic [31:0] epc0, epc1;
    int          ecount;
    logic        erdy;
    int          eiss, edual, esplit;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  ucsbece154b_dual_issue_scheduler_if #(.DEPTH(8), .CNT_W(32)) bus ();

  ucsbece154b_dual_issue_scheduler #(.DEPTH(8), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] cnt, input logic [31:0] i0, input logic [31:0] i1,
                     input logic [31:0] p0, input logic [31:0] p1, input logic fl,
                     input logic st, input logic ev0, input logic ev1,
                     input logic [31:0] epc0, input logic [31:0] epc1, input int ecount,
                     input logic erdy, input int eiss, input int edual, input int esplit);
    vec_t v;
    v.cnt = cnt; v.i0 = i0; v.i1 = i1; v.p0 = p0; v.p1 = p1;
    v.flush = fl; v.stall = st; v.ev0 = ev0; v.ev1 = ev1;
    v.epc0 = epc0; v.epc1 = epc1; v.ecount = ecount; v.erdy = erdy;
    v.eiss = eiss; v.edual = edual; v.esplit = esplit;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [1:0] cnt, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] p0, input logic [31:0] p1, input logic fl,
                       input logic st);
    bus.fetch_cnt_i = cnt;
    bus.fetch_instr0_i = i0;
    bus.fetch_instr1_i = i1;
    bus.fetch_pc0_i = p0;
    bus.fetch_pc1_i = p1;
    bus.flush_i = fl;
    bus.stall_i = st;
  endtask

  initial begin
    reset = 1'b0;
    drive(2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    //  cnt  i0     i1     p0      p1      fl st  v0 v1 pc0     pc1     cnt rdy iss dual split
    add(2'd0, 0,     0,     0,      0,      0, 0,  0, 0, 0,      0,      0, 1,  0, 0, 0);
    // independent pair
    add(2'd2, ADDI5, ADDI6, 32'h0,  32'h4,  0, 0,  0, 0, 0,      0,      0, 1,  0, 0, 0);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 1, 32'h0,  32'h4,  2, 1,  0, 0, 0);
    add(2'd0, 0,     0,     0,      0,      0, 0,  0, 0, 0,      0,      0, 1,  2, 1, 0);
    // RAW split
    add(2'd2, ADDI5, DEP6,  32'h0,  32'h4,  0, 0,  0, 0, 0,      0,      0, 1,  2, 1, 0);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 0, 32'h0,  0,      2, 1,  2, 1, 0);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 0, 32'h4,  0,      1, 1,  3, 1, 1);
    add(2'd0, 0,     0,     0,      0,      0, 0,  0, 0, 0,      0,      0, 1,  4, 1, 1);
    // control instruction in slot 0
    add(2'd2, BEQ,   ADDI5, 32'h8,  32'hC,  0, 0,  0, 0, 0,      0,      0, 1,  4, 1, 1);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 0, 32'h8,  0,      2, 1,  4, 1, 1);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 0, 32'hC,  0,      1, 1,  5, 1, 2);
    add(2'd0, 0,     0,     0,      0,      0, 0,  0, 0, 0,      0,      0, 1,  6, 1, 2);
    // fill under stall (pointers start at 6 so this wraps), fifth push dropped
    add(2'd2, ADDI5, ADDI6, 32'h100, 32'h104, 0, 1, 0, 0, 0,      0,      0, 1,  6, 1, 2);
    add(2'd2, ADDI5, ADDI6, 32'h108, 32'h10C, 0, 1, 1, 1, 32'h100, 32'h104, 2, 1, 6, 1, 2);
    add(2'd2, ADDI5, ADDI6, 32'h110, 32'h114, 0, 1, 1, 1, 32'h100, 32'h104, 4, 1, 6, 1, 2);
    add(2'd2, ADDI5, ADDI6, 32'h118, 32'h11C, 0, 1, 1, 1, 32'h100, 32'h104, 6, 1, 6, 1, 2);
    add(2'd2, ADDI5, ADDI6, 32'h120, 32'h124, 0, 1, 1, 1, 32'h100, 32'h104, 8, 0, 6, 1, 2);
    add(2'd2, ADDI5, ADDI6, 32'h120, 32'h124, 0, 0, 1, 1, 32'h100, 32'h104, 8, 0, 6, 1, 2);
    add(2'd2, ADDI5, ADDI6, 32'h120, 32'h124, 0, 0, 1, 1, 32'h108, 32'h10C, 6, 1, 8, 2, 2);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 1, 32'h110, 32'h114, 6, 1, 10, 3, 2);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 1, 32'h118, 32'h11C, 4, 1, 12, 4, 2);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 1, 32'h120, 32'h124, 2, 1, 14, 5, 2);
    add(2'd0, 0,     0,     0,      0,      0, 0,  0, 0, 0,      0,      0, 1, 16, 6, 2);
    // build count=5, then flush with a live fetch group
    add(2'd2, ADDI5, ADDI6, 32'h200, 32'h204, 0, 1, 0, 0, 0,      0,      0, 1, 16, 6, 2);
    add(2'd2, ADDI5, ADDI6, 32'h208, 32'h20C, 0, 1, 1, 1, 32'h200, 32'h204, 2, 1, 16, 6, 2);
    add(2'd1, ADDI5, 0,     32'h210, 0,      0, 1, 1, 1, 32'h200, 32'h204, 4, 1, 16, 6, 2);
    add(2'd2, ADDI5, ADDI6, 32'h300, 32'h304, 1, 1, 0, 0, 0,      0,      5, 1, 16, 6, 2);
    add(2'd0, 0,     0,     0,      0,      0, 0,  0, 0, 0,      0,      0, 1, 16, 6, 2);
    add(2'd2, ADDI5, ADDI6, 32'h400, 32'h404, 0, 0, 0, 0, 0,      0,      0, 1, 16, 6, 2);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 1, 32'h400, 32'h404, 2, 1, 16, 6, 2);
    // fetch_cnt=3 is ignored
    add(2'd3, ADDI5, ADDI6, 32'h480, 32'h484, 0, 0, 0, 0, 0,      0,      0, 1, 18, 7, 2);
    add(2'd0, 0,     0,     0,      0,      0, 0,  0, 0, 0,      0,      0, 1, 18, 7, 2);
    // WAW pair
    add(2'd2, ADDI5, ADDI5, 32'h500, 32'h504, 0, 0, 0, 0, 0,      0,      0, 1, 18, 7, 2);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 0, 32'h500, 0,      2, 1, 18, 7, 2);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 0, 32'h504, 0,      1, 1, 19, 7, 3);
    add(2'd0, 0,     0,     0,      0,      0, 0,  0, 0, 0,      0,      0, 1, 20, 7, 3);
    // two memory ops share one port
    add(2'd2, LW5,   LW6,   32'h600, 32'h604, 0, 0, 0, 0, 0,      0,      0, 1, 20, 7, 3);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 0, 32'h600, 0,      2, 1, 20, 7, 3);
    add(2'd0, 0,     0,     0,      0,      0, 0,  1, 0, 32'h604, 0,      1, 1, 21, 7, 4);
    add(2'd0, 0,     0,     0,      0,      0, 0,  0, 0, 0,      0,      0, 1, 22, 7, 4);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int r = 0; r < vq.size(); r++) begin
      if (r != 0) @(negedge clk);
      drive(vq[r].cnt, vq[r].i0, vq[r].i1, vq[r].p0, vq[r].p1, vq[r].flush, vq[r].stall);
      #2;
      chk("issue0_valid", r, 32'(bus.issue0_valid_o), 32'(vq[r].ev0));
      chk("issue1_valid", r, 32'(bus.issue1_valid_o), 32'(vq[r].ev1));
      if (vq[r].ev0) chk("issue0_pc", r, bus.issue0_pc_o, vq[r].epc0);
      if (vq[r].ev1) chk("issue1_pc", r, bus.issue1_pc_o, vq[r].epc1);
      chk("count", r, 32'(bus.count_o), 32'(vq[r].ecount));
      chk("fetch_ready", r, 32'(bus.fetch_ready_o), 32'(vq[r].erdy));
      chk("perf_issued", r, bus.perf_issued_o, 32'(vq[r].eiss));
      chk("perf_dual", r, bus.perf_dual_o, 32'(vq[r].edual));
      chk("perf_split", r, bus.perf_split_o, 32'(vq[r].esplit));
    end

    // mid-operation reset overrides a pending fetch group and clears the counters
    @(negedge clk);
    drive(2'd2, ADDI5, ADDI6, 32'h700, 32'h704, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    drive(2'd2, ADDI5, ADDI6, 32'h708, 32'h70C, 1'b0, 1'b1);
    #2;
    chk("pre_reset_count", 100, 32'(bus.count_o), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    drive(2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("rst_count", 101, 32'(bus.count_o), 32'd0);
    chk("rst_issue0_valid", 101, 32'(bus.issue0_valid_o), 32'd0);
    chk("rst_fetch_ready", 101, 32'(bus.fetch_ready_o), 32'd1);
    chk("rst_perf_issued", 101, bus.perf_issued_o, 32'd0);
    chk("rst_perf_dual", 101, bus.perf_dual_o, 32'd0);
    chk("rst_perf_split", 101, bus.perf_split_o, 32'd0);
    @(negedge clk);
    #2;
    chk("post_rst_count", 102, 32'(bus.count_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
